// File: rtl/edge_level_pkg.sv
// edge_level_pkg: shared state/pending encodings and widths for edge_level_driver.
package edge_level_pkg;
    typedef enum logic {SETTLED = 1'b0, HOLD = 1'b1} state_t;
    typedef enum logic {NONE = 1'b0, CHANGE = 1'b1} pending_t;
    localparam int DROP_CNT_W = 8;
endpackage

// File: rtl/edge_level_driver_hold_timer.sv
// hold_timer: loadable down-counter with a registered zero flag.
// The counter stops at zero instead of wrapping.
module hold_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            zero <= 1'b1;
        end else if (load) begin
            cnt  <= load_val;
            zero <= (load_val == '0);
        end else if (tick && cnt != '0) begin
            cnt  <= cnt - W'(1);
            zero <= (cnt == W'(1));
        end
    end
endmodule

// File: rtl/edge_level_driver.sv
// edge_level_driver: rebuilds a level from rise/fall pulses with a minimum dwell per level.
// Build option: EDGE_LEVEL_DROP_CNT_EN enables the saturating cancelled-pair counter.
module edge_level_driver
    import edge_level_pkg::*;
#(
    parameter int   HOLD_CYCLES = 50000,
    parameter logic RESET_LEVEL = 1'b0,
    parameter int   CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rise,
    input  logic                  fall,
    output logic                  level,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] dropped_cnt
);
    state_t   state;
    pending_t pending;
    pending_t pend_fold;
    logic     zero, single, opp, match, expire, toggle;

    assign single = rise ^ fall;
    assign opp    = single & (rise != level);
    assign match  = single & (rise == level);
    // A request arriving on the expiry cycle is folded in before the decision.
    assign pend_fold = (pending == NONE) ? (opp ? CHANGE : NONE) : (match ? NONE : CHANGE);
    assign expire = (state == HOLD) & zero;
    assign toggle = (state == SETTLED) ? opp : (expire & (pend_fold == CHANGE));
    assign busy   = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            level   <= RESET_LEVEL;
            state   <= SETTLED;
            pending <= NONE;
        end else begin
            if (toggle) level <= ~level;
            state   <= toggle ? HOLD : (expire ? SETTLED : state);
            pending <= (state == SETTLED || expire) ? NONE : pend_fold;
        end
    end

    hold_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (toggle),
        .load_val (CNT_W'(HOLD_CYCLES - 1)),
        .tick     (busy),
        .zero     (zero)
    );

`ifdef EDGE_LEVEL_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q;
    logic                  drop_inc;

    assign drop_inc = (state == HOLD) & (pending == CHANGE) & match;

    always_ff @(posedge clk) begin
        if (rst) drop_q <= '0;
        else if (drop_inc && drop_q != '1) drop_q <= drop_q + DROP_CNT_W'(1);
    end

    assign dropped_cnt = drop_q;
`else
    assign dropped_cnt = '0;
`endif
endmodule

// File: tb/tb_edge_level_driver.sv
// tb_edge_level_driver: directed vectors with a queue-based scoreboard, HOLD_CYCLES=4.
module tb_edge_level_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rise = 1'b0;
    logic       fall = 1'b0;
    logic       level, busy;
    logic [7:0] dropped_cnt;

    typedef struct {
        logic       l;
        logic       b;
        logic [7:0] d;
        logic       cl;
        logic       cd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    edge_level_driver #(.HOLD_CYCLES(4), .RESET_LEVEL(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .rise        (rise),
        .fall        (fall),
        .level       (level),
        .busy        (busy),
        .dropped_cnt (dropped_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dx(input int d);
`ifdef EDGE_LEVEL_DROP_CNT_EN
        return 8'(d);
`else
        return 8'(d * 0);
`endif
    endfunction

    // Inputs held for one cycle; expected outputs are those seen after the next rising edge.
    task automatic step(input logic r, input logic f, input logic s, input logic el, input logic eb,
                        input int ed, input logic cl = 1'b1, input logic cd = 1'b1);
        exp_t e;
        @(negedge clk);
        rise = r;
        fall = f;
        rst  = s;
        e.l = el; e.b = eb; e.d = dx(ed); e.cl = cl; e.cd = cd;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.cl) begin
                checks++;
                if (level !== e.l) begin errors++; $display("FAIL level got %b exp %b t=%0t", level, e.l, $time); end
                checks++;
                if (busy !== e.b) begin errors++; $display("FAIL busy got %b exp %b t=%0t", busy, e.b, $time); end
            end
            if (e.cd) begin
                checks++;
                if (dropped_cnt !== e.d) begin errors++; $display("FAIL dropped_cnt got %0d exp %0d t=%0t", dropped_cnt, e.d, $time); end
            end
        end
    end

    initial begin
        // reset and idle
        step(0,0,1, 0,0,0);
        step(0,0,0, 0,0,0);
        // single rise: 4-cycle dwell then settle high
        step(1,0,0, 1,1,0);
        repeat (3) step(0,0,0, 1,1,0);
        step(0,0,0, 1,0,0);
        step(0,0,0, 1,0,0);
        // rise then fall mid-dwell: fall applied at expiry
        step(0,0,1, 0,0,0);
        step(1,0,0, 1,1,0);
        step(0,0,0, 1,1,0);
        step(0,1,0, 1,1,0);
        step(0,0,0, 1,1,0);
        repeat (4) step(0,0,0, 0,1,0);
        step(0,0,0, 0,0,0);
        // rise, fall, rise: cancelled pair
        step(0,0,1, 0,0,0);
        step(1,0,0, 1,1,0);
        step(0,1,0, 1,1,0);
        step(1,0,0, 1,1,1);
        step(0,0,0, 1,1,1);
        step(0,0,0, 1,0,1);
        step(0,0,0, 1,0,1);
        // fall sampled on the expiry cycle
        step(0,0,1, 0,0,0);
        step(1,0,0, 1,1,0);
        repeat (3) step(0,0,0, 1,1,0);
        step(0,1,0, 0,1,0);
        repeat (3) step(0,0,0, 0,1,0);
        step(0,0,0, 0,0,0);
        // simultaneous rise&fall while settled
        step(0,0,1, 0,0,0);
        step(1,1,0, 0,0,0);
        step(0,0,0, 0,0,0);
        // reset mid-dwell with pending fall, then a clean dwell
        step(1,0,0, 1,1,0);
        step(0,1,0, 1,1,0);
        step(0,0,1, 0,0,0);
        step(0,0,0, 0,0,0);
        step(1,0,0, 1,1,0);
        repeat (3) step(0,0,0, 1,1,0);
        step(0,0,0, 1,0,0);
        // saturation: alternating requests yield ~2 cancelled pairs per 5 cycles
        step(0,0,1, 0,0,0);
        step(1,0,0, 0,0,0, 1'b0, 1'b0);
        for (int i = 0; i < 800; i++) step(logic'(i % 2), logic'((i + 1) % 2), 0, 0,0,0, 1'b0, 1'b0);
        step(0,0,0, 0,0,255, 1'b0, 1'b1);
        step(0,0,0, 0,0,255, 1'b0, 1'b1);
        @(negedge clk);
        rise = 1'b0;
        fall = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL queue_drain got %0d exp 0", q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
